clock_time_ctrl: RTL

//  Time-keeping controller for the digital clock. Holds BCD seconds, minutes and hours.

---
 rtl/clock_time_ctrl_if.sv | 34 +++
 rtl/clock_time_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/clock_time_ctrl_if.sv
// Button inputs and time/display outputs of the clock time-keeping controller.
// The controller uses the slave view; whatever drives the buttons uses the master view.
interface clock_time_ctrl_if;
    logic       btn_mode;
    logic       btn_inc;
    logic [7:0] sec_bcd;
    logic [7:0] min_bcd;
    logic [7:0] hour_bcd;
    logic [1:0] mode;
    logic       blink;
    logic       hour_chime;

    modport slave (
        input  btn_mode,
        input  btn_inc,
        output sec_bcd,
        output min_bcd,
        output hour_bcd,
        output mode,
        output blink,
        output hour_chime
    );

    modport master (
        output btn_mode,
        output btn_inc,
        input  sec_bcd,
        input  min_bcd,
        input  hour_bcd,
        input  mode,
        input  blink,
        input  hour_chime
    );
endinterface

// File: rtl/clock_time_ctrl.sv
// BCD time-of-day keeper with 1 Hz prescaler, hour/minute set mode FSM,
// set-field blink and hour chime.  All outputs come straight from flops.
//
//   state   | meaning
//   --------+--------------------------------------------------------
//   RUN     | time advances once per TICKS_PER_SEC cycles, chime on xx:00:00
//   SET_HR  | time paused, inc event bumps hours mod 24, blink active
//   SET_MIN | time paused, inc event bumps minutes mod 60, blink active
module clock_time_ctrl #(
    parameter int TICKS_PER_SEC = 50_000_000
) (
    input  logic              clk,
    input  logic              reset,
    clock_time_ctrl_if.slave  bus
);

    localparam int HALF_SEC = TICKS_PER_SEC / 2;
    localparam int PRE_W    = $clog2(TICKS_PER_SEC);
    localparam int BLK_W    = (HALF_SEC > 1) ? $clog2(HALF_SEC) : 1;

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICKS_PER_SEC - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(HALF_SEC - 1);

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        SET_HR  = 2'b01,
        SET_MIN = 2'b10
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         sec_q, sec_d;
    logic [7:0]         min_q, min_d;
    logic [7:0]         hour_q, hour_d;
    logic [PRE_W-1:0]   prescaler_q, prescaler_d;
    logic [BLK_W-1:0]   blink_cnt_q, blink_cnt_d;
    logic               blink_q, blink_d;
    logic               chime_q, chime_d;
    logic               btn_mode_prev_q, btn_mode_prev_d;
    logic               btn_inc_prev_q, btn_inc_prev_d;

    logic               mode_evt;
    logic               inc_evt;
    logic               tick;
    logic [8:0]         sec_inc;
    logic [8:0]         min_inc;
    logic [8:0]         hour_inc;

    // Returns {wrapped, next_value}; wraps to 00 after 'last'.
    function automatic logic [8:0] bcd_inc(input logic [7:0] v, input logic [7:0] last);
        logic [8:0] r;
        if (v == last) begin
            r = {1'b1, 8'h00};
        end else if (v[3:0] == 4'd9) begin
            r = {1'b0, v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {1'b0, v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    always_comb begin
        mode_evt = bus.btn_mode & ~btn_mode_prev_q;
        inc_evt  = bus.btn_inc & ~btn_inc_prev_q & ~mode_evt;
        tick     = (state_q == RUN) && (prescaler_q == PRE_LAST);
        sec_inc  = bcd_inc(sec_q, 8'h59);
        min_inc  = bcd_inc(min_q, 8'h59);
        hour_inc = bcd_inc(hour_q, 8'h23);
    end

    always_comb begin
        state_d         = state_q;
        sec_d           = sec_q;
        min_d           = min_q;
        hour_d          = hour_q;
        prescaler_d     = prescaler_q;
        blink_cnt_d     = blink_cnt_q;
        blink_d         = blink_q;
        chime_d         = 1'b0;
        btn_mode_prev_d = bus.btn_mode;
        btn_inc_prev_d  = bus.btn_inc;

        case (state_q)
            RUN: begin
                blink_d     = 1'b0;
                blink_cnt_d = '0;
                if (tick) begin
                    prescaler_d = '0;
                    sec_d       = sec_inc[7:0];
                    if (sec_inc[8]) begin
                        min_d = min_inc[7:0];
                        if (min_inc[8]) begin
                            hour_d = hour_inc[7:0];
                        end
                    end
                    chime_d = sec_inc[8] & min_inc[8];
                end else begin
                    prescaler_d = prescaler_q + 1'b1;
                end
                if (mode_evt) begin
                    state_d     = SET_HR;
                    prescaler_d = '0;
                end
            end
            SET_HR: begin
                prescaler_d = '0;
                if (mode_evt) begin
                    state_d = SET_MIN;
                end else if (inc_evt) begin
                    hour_d = hour_inc[7:0];
                end
            end
            SET_MIN: begin
                prescaler_d = '0;
                if (mode_evt) begin
                    state_d = RUN;
                    sec_d   = 8'h00;
                end else if (inc_evt) begin
                    min_d = min_inc[7:0];
                end
            end
            default: begin
                state_d     = RUN;
                prescaler_d = '0;
            end
        endcase

        // Every mode entry restarts the blink phase with the field visible.
        if (state_q != RUN) begin
            if (mode_evt) begin
                blink_d     = 1'b0;
                blink_cnt_d = '0;
            end else if (blink_cnt_q == BLK_LAST) begin
                blink_d     = ~blink_q;
                blink_cnt_d = '0;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= RUN;
            sec_q           <= 8'h00;
            min_q           <= 8'h00;
            hour_q          <= 8'h00;
            prescaler_q     <= '0;
            blink_cnt_q     <= '0;
            blink_q         <= 1'b0;
            chime_q         <= 1'b0;
            btn_mode_prev_q <= 1'b0;
            btn_inc_prev_q  <= 1'b0;
        end else begin
            state_q         <= state_d;
            sec_q           <= sec_d;
            min_q           <= min_d;
            hour_q          <= hour_d;
            prescaler_q     <= prescaler_d;
            blink_cnt_q     <= blink_cnt_d;
            blink_q         <= blink_d;
            chime_q         <= chime_d;
            btn_mode_prev_q <= btn_mode_prev_d;
            btn_inc_prev_q  <= btn_inc_prev_d;
        end
    end

    assign bus.sec_bcd    = sec_q;
    assign bus.min_bcd    = min_q;
    assign bus.hour_bcd   = hour_q;
    assign bus.mode       = state_q;
    assign bus.blink      = blink_q;
    assign bus.hour_chime = chime_q;

endmodule
